// File: rtl/tdm_demux_1x8.sv
// Time-division demultiplexer: rebuilds eight parallel lanes from an 8-slot serial stream
// aligned by a frame-start marker, with a frame-complete strobe and a resync error strobe.
//
// state    | meaning
// UNLOCKED | no alignment yet; samples without frame_start are dropped
// LOCKED   | slot counter tracks the sender; frames are assembled and emitted
module tdm_demux_1x8 #(
  parameter int DW = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [DW-1:0]   din,
  input  logic            din_valid,
  input  logic            frame_start,
  output logic [8*DW-1:0] dout,
  output logic            dout_valid,
  output logic [2:0]      slot,
  output logic            locked,
  output logic            sync_err
);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        slot_q, slot_d;
  // Slots 0..6 only; slot 7 goes straight from din into dout.
  logic [7*DW-1:0]   shadow_q, shadow_d;
  logic [8*DW-1:0]   dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              sync_err_q, sync_err_d;

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    shadow_d     = shadow_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    sync_err_d   = 1'b0;
    if (din_valid) begin
      unique case (state_q)
        UNLOCKED: begin
          if (frame_start) begin
            shadow_d[DW-1:0] = din;
            slot_d           = 3'd1;
            state_d          = LOCKED;
          end
        end
        LOCKED: begin
          if (frame_start && (slot_q != 3'd0)) begin
            // Short frame: drop what was gathered and restart at slot 0 with this sample.
            sync_err_d       = 1'b1;
            shadow_d[DW-1:0] = din;
            slot_d           = 3'd1;
          end else if (slot_q == 3'd7) begin
            dout_d       = {din, shadow_q};
            dout_valid_d = 1'b1;
            slot_d       = 3'd0;
          end else begin
            for (int k = 0; k < 7; k++) begin
              if (slot_q == 3'(k)) shadow_d[k*DW +: DW] = din;
            end
            slot_d = slot_q + 3'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= UNLOCKED;
      slot_q       <= 3'd0;
      shadow_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      shadow_q     <= shadow_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign slot       = slot_q;
  assign locked     = (state_q == LOCKED);
  assign sync_err   = sync_err_q;

endmodule

// File: doc/tdm_demux_1x8.md
Name: tdm_demux_1x8

Overview:
- Receiving end of the 8:1 selector path: a time-division demultiplexer (TDM).
- An upstream 8:1 mux serialises eight lanes as slots 0..7, with sel counting 0..7. This block takes that slot stream back to eight parallel registered lanes.
- Holds a slot counter aligned by a frame-start marker. Presents a complete 8-lane word with a one-cycle valid strobe, and flags framing errors.

Parameters:
- DW, 1, data width per lane/slot in bits (must be >= 1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- din  input  DW  serial slot data
- din_valid  input  1  din carries a slot sample this cycle
- frame_start  input  1  qualifies current valid sample as slot 0; ignored when din_valid=0
- dout  output  8*DW  assembled frame; slot k at dout[k*DW +: DW]
- dout_valid  output  1  one-cycle strobe: dout updated with a complete frame
- slot  output  3  slot index the next accepted sample will be written to
- locked  output  1  frame alignment acquired
- sync_err  output  1  one-cycle strobe: frame_start arrived mid-frame

Behaviour:
- Reset: rst_n sampled low at a clk edge clears everything.
  - dout=0, dout_valid=0, slot=0, locked=0, sync_err=0.
  - Shadow register is cleared and any partial frame is discarded.
  - Reset asserted mid-frame behaves identically.
- Accept: a sample is accepted on a rising edge when din_valid=1 (and rst_n=1). No backpressure; din_valid may have arbitrary gaps between slots and the frame simply stretches.
- States (the locked bit):
  - UNLOCKED:
    - Accepted samples with frame_start=0 are dropped; slot stays 0.
    - An accepted sample with frame_start=1 writes shadow[0], sets slot=1 and goes to LOCKED.
  - LOCKED:
    - Each accepted sample writes shadow[slot], then slot increments modulo 8.
    - frame_start=1 with slot=0 is the normal frame boundary; no error.
    - frame_start=1 with slot!=0 means a short frame: sync_err=1 for the next cycle, the partial frame is discarded (no dout_valid), the sample is written to shadow[0] and slot=1. The state remains LOCKED.
- Frame completion: when a sample is accepted with slot=7 (and no resync on that sample):
  - On the same edge, dout <= {din, shadow[6:0]}, dout_valid=1 for exactly that following cycle, slot wraps to 0.
  - dout holds its value until the next completed frame.
- Back-to-back frames with no idle cycles are supported. The slot-0 sample of the next frame may arrive in the cycle dout_valid is high.
- frame_start on a sample accepted at slot=7 is a short frame: sync_err, no dout_valid.
- Latency: 1 cycle from the edge accepting slot 7 to dout_valid being visible.
- Lane mapping: slot k maps to lane k. A sender driving sel=k with x[k] reproduces x on dout.
- The slot output is registered and equals the internal counter.
- dout_valid and sync_err are mutually exclusive in any cycle.

Test Plan:
- Basic frame, DW=1: after reset, send 8 valid samples of x=8'b01001001 (slot0=1, slot1=0, slot2=0, slot3=1, slot4=0, slot5=0, slot6=1, slot7=0), frame_start on the first -> one cycle after the 8th sample, dout=8'h49, dout_valid high 1 cycle, slot=0, locked=1, sync_err=0.
- Gapped valid: same frame with din_valid low for 1-3 random cycles between slots -> identical dout=8'h49 with a single dout_valid pulse; slot does not advance during gaps.
- Pre-lock drop: 5 valid samples with frame_start=0 after reset, then a full frame 8'hA5 with frame_start on slot 0 -> locked rises after the frame_start sample; only one dout_valid occurs, with dout=8'hA5.
- Short frame: locked; send 3 samples of a frame, then frame_start with a new frame 8'h3C -> sync_err pulses 1 cycle and there is no dout_valid for the partial frame; then dout=8'h3C with dout_valid.
- Back-to-back plus reset: frames 8'hFF then 8'h00 continuously -> two dout_valid pulses exactly 8 cycles apart. Then, mid-third-frame at slot 4, drive rst_n=0 for 1 cycle -> all outputs 0, locked=0, no dout_valid for the partial frame.
- DW=4: frame with slot k = k+1 -> dout=32'h87654321 with one dout_valid pulse.
